// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: button channel indices, auto-repeat state encoding
// and counter sizing helper.
package tetris;

  localparam int btn_left_c   = 0;
  localparam int btn_right_c  = 1;
  localparam int btn_rotate_c = 2;
  localparam int btn_start_c  = 3;

  typedef enum logic [1:0] {e_rep_idle, e_rep_delay, e_rep_repeat} repeat_state_e;

  // Width able to hold 0..max_count; never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One button channel: optional inversion, 2-flop synchroniser, stable-count
// debounce and single-cycle press/release pulses aligned with the level change.
module button_debounce
  import tetris::*;
#(
  parameter int   debounce_cycles_p = 250000,
  parameter logic invert_p          = 1'b0
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int               cw_lp      = cnt_width(debounce_cycles_p - 1);
  localparam logic [cw_lp-1:0] cnt_max_lp = cw_lp'(debounce_cycles_p - 1);

  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             press_q, press_d, release_q, release_d;
  logic [cw_lp-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d   = btn_i ^ invert_p;
    sync2_d   = sync1_q;
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    // Any sample equal to the stable level drops cnt back to 0.
    if (sync2_q != stable_q) begin
      if (cnt_q == cnt_max_lp) begin
        stable_d  = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      cnt_q     <= cnt_d;
    end
  end

  assign level_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_frontend.sv
// N-channel debounced button front end with optional delayed-auto-shift fire
// stream, built only when BUTTON_FRONTEND_AUTOREPEAT_EN is defined.
module button_frontend
  import tetris::*;
#(
  parameter int                    channels_p             = 4,
  parameter logic [channels_p-1:0] invert_p               = '0,
  parameter int                    debounce_cycles_p      = 250000,
  parameter int                    repeat_delay_cycles_p  = 8000000,
  parameter int                    repeat_period_cycles_p = 2500000
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [channels_p-1:0] btn_i,
  input  logic [channels_p-1:0] repeat_en_i,
  output logic [channels_p-1:0] level_o,
  output logic [channels_p-1:0] press_o,
  output logic [channels_p-1:0] release_o,
  output logic [channels_p-1:0] fire_o
);

  logic [channels_p-1:0] level, press;

  for (genvar i = 0; i < channels_p; i++) begin : g_ch
    button_debounce #(
      .debounce_cycles_p(debounce_cycles_p),
      .invert_p         (invert_p[i])
    ) u_deb (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .btn_i    (btn_i[i]),
      .level_o  (level[i]),
      .press_o  (press[i]),
      .release_o(release_o[i])
    );
  end

  assign level_o = level;
  assign press_o = press;

`ifdef BUTTON_FRONTEND_AUTOREPEAT_EN
  localparam int rmax_lp = ((repeat_delay_cycles_p > repeat_period_cycles_p) ?
                            repeat_delay_cycles_p : repeat_period_cycles_p) - 1;
  localparam int                rw_lp        = cnt_width(rmax_lp);
  localparam logic [rw_lp-1:0]  delay_max_lp  = rw_lp'(repeat_delay_cycles_p - 1);
  localparam logic [rw_lp-1:0]  period_max_lp = rw_lp'(repeat_period_cycles_p - 1);

  for (genvar i = 0; i < channels_p; i++) begin : g_rep
    repeat_state_e    state_q, state_d;
    logic [rw_lp-1:0] rcnt_q, rcnt_d;
    logic             tick;

    always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      tick    = 1'b0;
      case (state_q)
        e_rep_idle: begin
          rcnt_d = '0;
          if (press[i] && repeat_en_i[i]) state_d = e_rep_delay;
        end
        e_rep_delay: begin
          if (rcnt_q == delay_max_lp) begin
            tick    = 1'b1;
            state_d = e_rep_repeat;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        e_rep_repeat: begin
          if (rcnt_q == period_max_lp) begin
            tick   = 1'b1;
            rcnt_d = '0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
        default: state_d = e_rep_idle;
      endcase
      // Release or losing the enable aborts the sequence without a final fire.
      if (state_q != e_rep_idle && (!level[i] || !repeat_en_i[i])) begin
        state_d = e_rep_idle;
        rcnt_d  = '0;
        tick    = 1'b0;
      end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        state_q <= e_rep_idle;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        rcnt_q  <= rcnt_d;
      end
    end

    assign fire_o[i] = press[i] | tick;
  end
`else
  logic unused_repeat_en;
  assign unused_repeat_en = ^repeat_en_i;
  assign fire_o           = press;
`endif

endmodule
